gcd_8_seq: RTL and testbench
============================

Name: gcd_8_seq

Overview:
- Sequential 8-bit greatest-common-divisor engine using subtractive Euclid, one compare/subtract per clock.
- Sits directly upstream of the 8-bit result register: its `result`/`done` pair drives that register's data input and load qualifier.
- Uses a start/busy/done handshake so a controller can issue back-to-back operations.

Parameters:
- WIDTH, 8, operand and result width in bits. Verified only at 8.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; captured on an accepted start.
- b  input  WIDTH  operand B; captured on an accepted start.
- busy  output  1  high while in CALC.
- done  output  1  one-cycle pulse; high exactly while in DONE.
- result  output  WIDTH  GCD of the last completed operation; held until the next completion.
- iter_count  output  8  number of CALC cycles used by the last completed operation.

Behaviour:
- Reset: on any posedge with rst=1:
  - state<=IDLE; x, y, result, iter_count, internal counter <= 0; busy=0, done=0.
  - rst has priority over start and all FSM activity, including mid-CALC; the in-flight operation is discarded.
- All outputs are registered or decoded from the state register only; no combinational path from inputs to outputs.
- State IDLE:
  - busy=0, done=0.
  - If start=1: x<=a, y<=b, cnt<=0, go to CALC. Otherwise stay.
- State CALC: busy=1, done=0. Each cycle cnt<=cnt+1, then evaluate in this priority order:
  - y==0: result<=x, go to DONE. This gives gcd(x,0)=x and gcd(0,0)=0.
  - x==0: result<=y, go to DONE.
  - x==y: result<=x, go to DONE.
  - x>y: x<=x-y, stay in CALC.
  - otherwise: y<=y-x, stay in CALC.
  - On every transition to DONE: iter_count<=cnt+1.
- Arithmetic: unsigned WIDTH-bit subtraction only. It never underflows because the larger operand is always the minuend.
- State DONE: busy=0, done=1 for exactly one cycle.
  - If start=1: capture a, b, cnt<=0, go to CALC. This is the back-to-back case.
  - Otherwise go to IDLE.
- start while busy: ignored; operands are not re-sampled.
- Latency:
  - Accepted start at edge E0 → CALC during cycles after E0 … E0+N → done high in the cycle after edge E0+N, where N = iter_count.
  - Worst case N=255 (a=255,b=1 or a=1,b=255), so the 8-bit count never overflows.
- result and iter_count are unchanged from DONE until the next transition into DONE.
- The downstream register loads result when done=1.

Test Plan:
- Reset: rst=1 for 2 cycles with start=1, a=12, b=8 → busy=0, done=0, result=0, iter_count=0; no CALC entered.
- Basic: start pulse with a=12, b=8 → busy for 3 cycles; then done=1 for 1 cycle, result=4, iter_count=3; then IDLE, and result stays 4.
- Zero operands:
  - a=0, b=9 → result=9, iter_count=1.
  - a=9, b=0 → result=9, iter_count=1.
  - a=0, b=0 → result=0, iter_count=1.
- Worst case and back-to-back:
  - a=255, b=1 → done after 255 CALC cycles, result=1, iter_count=255.
  - During that DONE cycle assert start with a=48, b=18 → next pass yields result=6, iter_count=5 (48,18→30,18→12,18→12,6→6,6), with no IDLE gap.
- Ignored start and mid-op reset:
  - Start a=100, b=75; pulse start with a=7, b=3 while busy → result=25, iter_count=4.
  - Repeat the first operation, asserting rst on the 2nd CALC cycle → next cycle IDLE, busy=0, result=0, no done pulse.

Source files
------------

// File: rtl/gcd_8_seq_if.sv
// Start/busy/done handshake bundle for the sequential GCD engine.
// The controller uses the master side; the engine uses the slave side.
interface gcd_8_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [7:0]       iter_count;

  modport master (
    output start, a, b,
    input  busy, done, result, iter_count
  );

  modport slave (
    input  start, a, b,
    output busy, done, result, iter_count
  );
endinterface

// File: rtl/gcd_8_seq.sv
// Subtractive-Euclid GCD engine: one compare/subtract per clock, start/busy/done handshake.
// result/iter_count hold the last completed operation until the next one completes.
module gcd_8_seq #(
  parameter int WIDTH = 8
) (
  input logic        clk,
  input logic        rst,
  gcd_8_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [7:0]       cnt;
  logic [WIDTH-1:0] result_q;
  logic [7:0]       iter_q;
  logic             finish;
  logic             accept;

  // Termination test is shared by next-state logic and the datapath.
  always_comb begin
    finish = (y == '0) || (x == '0) || (x == y);
    accept = ((state == IDLE) || (state == DONE)) && bus.start;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = accept ? CALC : IDLE;
      CALC:    state_next = finish ? DONE : CALC;
      DONE:    state_next = accept ? CALC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy       = (state == CALC);
    bus.done       = (state == DONE);
    bus.result     = result_q;
    bus.iter_count = iter_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x        <= '0;
      y        <= '0;
      cnt      <= '0;
      result_q <= '0;
      iter_q   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            x   <= bus.a;
            y   <= bus.b;
            cnt <= '0;
          end
        end
        CALC: begin
          cnt <= cnt + 8'd1;
          // Priority order makes gcd(x,0)=x and gcd(0,0)=0 fall out of the y==0 arm.
          if (y == '0) begin
            result_q <= x;
            iter_q   <= cnt + 8'd1;
          end else if (x == '0) begin
            result_q <= y;
            iter_q   <= cnt + 8'd1;
          end else if (x == y) begin
            result_q <= x;
            iter_q   <= cnt + 8'd1;
          end else if (x > y) begin
            x <= x - y;
          end else begin
            y <= y - x;
          end
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_8_seq.sv
// Directed-vector bench for gcd_8_seq: reset, basic, zero operands, worst case,
// back-to-back, ignored start and mid-operation reset.
module tb_gcd_8_seq;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  gcd_8_seq_if #(.WIDTH(8)) bus ();

  gcd_8_seq #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for done; counts busy cycles seen on the way.
  task automatic wait_done(output int busy_cycles, output bit seen);
    int n;
    busy_cycles = 0;
    n = 0;
    while (bus.done !== 1'b1 && n < 300) begin
      if (bus.busy === 1'b1) busy_cycles++;
      tick();
      n++;
    end
    seen = (bus.done === 1'b1);
  endtask

  task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                        output int busy_cycles, output bit seen);
    bus.start = 1'b1;
    bus.a = av;
    bus.b = bv;
    tick();
    bus.start = 1'b0;
    wait_done(busy_cycles, seen);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b1;
    bus.a = 8'd12;
    bus.b = 8'd8;
    tick();
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_busy_c1: got %b expected 0", bus.busy);
    end
    tick();
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_busy: got %b expected 0", bus.busy);
    end
    vectors++;
    if (bus.done !== 1'b0) begin
      miscompares++; $display("FAIL reset_done: got %b expected 0", bus.done);
    end
    vectors++;
    if (bus.result !== 8'd0) begin
      miscompares++; $display("FAIL reset_result: got %0d expected 0", bus.result);
    end
    vectors++;
    if (bus.iter_count !== 8'd0) begin
      miscompares++; $display("FAIL reset_iter: got %0d expected 0", bus.iter_count);
    end
    rst = 1'b0;
    bus.start = 1'b0;
    tick();
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_release_busy: got %b expected 0", bus.busy);
    end
  endtask

  task automatic test_basic();
    int  bc;
    bit  seen;
    run_op(8'd12, 8'd8, bc, seen);
    vectors++;
    if (seen !== 1'b1) begin
      miscompares++; $display("FAIL basic_timeout: got %b expected 1", seen);
    end
    vectors++;
    if (bc !== 3) begin
      miscompares++; $display("FAIL basic_busy_cycles: got %0d expected 3", bc);
    end
    vectors++;
    if (bus.result !== 8'd4) begin
      miscompares++; $display("FAIL basic_result: got %0d expected 4", bus.result);
    end
    vectors++;
    if (bus.iter_count !== 8'd3) begin
      miscompares++; $display("FAIL basic_iter: got %0d expected 3", bus.iter_count);
    end
    tick();
    vectors++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++; $display("FAIL basic_idle: got done=%b busy=%b expected 0 0", bus.done, bus.busy);
    end
    tick();
    tick();
    vectors++;
    if (bus.result !== 8'd4) begin
      miscompares++; $display("FAIL basic_hold: got %0d expected 4", bus.result);
    end
  endtask

  task automatic test_zero();
    logic [7:0] ta [3] = '{8'd0, 8'd9, 8'd0};
    logic [7:0] tb [3] = '{8'd9, 8'd0, 8'd0};
    logic [7:0] tr [3] = '{8'd9, 8'd9, 8'd0};
    int  bc;
    bit  seen;
    for (int i = 0; i < 3; i++) begin
      run_op(ta[i], tb[i], bc, seen);
      vectors++;
      if (seen !== 1'b1 || bc !== 1) begin
        miscompares++; $display("FAIL zero_%0d_latency: got seen=%b busy=%0d expected 1 1", i, seen, bc);
      end
      vectors++;
      if (bus.result !== tr[i]) begin
        miscompares++; $display("FAIL zero_%0d_result: got %0d expected %0d", i, bus.result, tr[i]);
      end
      vectors++;
      if (bus.iter_count !== 8'd1) begin
        miscompares++; $display("FAIL zero_%0d_iter: got %0d expected 1", i, bus.iter_count);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int  bc;
    bit  seen;
    run_op(8'd255, 8'd1, bc, seen);
    vectors++;
    if (seen !== 1'b1 || bc !== 255) begin
      miscompares++; $display("FAIL worst_latency: got seen=%b busy=%0d expected 1 255", seen, bc);
    end
    vectors++;
    if (bus.result !== 8'd1 || bus.iter_count !== 8'd255) begin
      miscompares++; $display("FAIL worst_values: got result=%0d iter=%0d expected 1 255", bus.result, bus.iter_count);
    end
    bus.start = 1'b1;
    bus.a = 8'd48;
    bus.b = 8'd18;
    tick();
    bus.start = 1'b0;
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++; $display("FAIL b2b_no_gap: got busy=%b expected 1", bus.busy);
    end
    wait_done(bc, seen);
    vectors++;
    if (seen !== 1'b1 || bc !== 5) begin
      miscompares++; $display("FAIL b2b_latency: got seen=%b busy=%0d expected 1 5", seen, bc);
    end
    vectors++;
    if (bus.result !== 8'd6 || bus.iter_count !== 8'd5) begin
      miscompares++; $display("FAIL b2b_values: got result=%0d iter=%0d expected 6 5", bus.result, bus.iter_count);
    end
    tick();
  endtask

  task automatic test_ignored_start();
    int  bc;
    bit  seen;
    bus.start = 1'b1;
    bus.a = 8'd100;
    bus.b = 8'd75;
    tick();
    bus.start = 1'b0;
    tick();
    bus.start = 1'b1;
    bus.a = 8'd7;
    bus.b = 8'd3;
    tick();
    bus.start = 1'b0;
    bus.a = 8'd0;
    bus.b = 8'd0;
    wait_done(bc, seen);
    vectors++;
    if (seen !== 1'b1) begin
      miscompares++; $display("FAIL ignore_timeout: got %b expected 1", seen);
    end
    vectors++;
    if (bus.result !== 8'd25 || bus.iter_count !== 8'd4) begin
      miscompares++; $display("FAIL ignore_values: got result=%0d iter=%0d expected 25 4", bus.result, bus.iter_count);
    end
    tick();
  endtask

  task automatic test_mid_reset();
    int dones;
    bus.start = 1'b1;
    bus.a = 8'd100;
    bus.b = 8'd75;
    tick();
    bus.start = 1'b0;
    tick();
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++; $display("FAIL midrst_calc2: got busy=%b expected 1", bus.busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      miscompares++; $display("FAIL midrst_idle: got busy=%b done=%b expected 0 0", bus.busy, bus.done);
    end
    vectors++;
    if (bus.result !== 8'd0 || bus.iter_count !== 8'd0) begin
      miscompares++; $display("FAIL midrst_clear: got result=%0d iter=%0d expected 0 0", bus.result, bus.iter_count);
    end
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
    end
    vectors++;
    if (dones !== 0) begin
      miscompares++; $display("FAIL midrst_no_done: got %0d active cycles expected 0", dones);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    test_reset();
    test_basic();
    test_zero();
    test_back_to_back();
    test_ignored_start();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
